// File: rtl/uart_rx_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_pkg
// Purpose  : Shared encodings for the DZ11 line receiver: character length,
//            parity and stop-bit codes, receiver states and bit-timing loads.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

  localparam logic [1:0] UARTLEN_5    = 2'd0;
  localparam logic [1:0] UARTLEN_6    = 2'd1;
  localparam logic [1:0] UARTLEN_7    = 2'd2;
  localparam logic [1:0] UARTLEN_8    = 2'd3;

  localparam logic [1:0] UARTPAR_NONE = 2'd0;
  localparam logic [1:0] UARTPAR_EVEN = 2'd1;
  localparam logic [1:0] UARTPAR_ODD  = 2'd2;

  localparam logic       UARTSTOP_1   = 1'b0;
  localparam logic       UARTSTOP_2   = 1'b1;

  // Divider loads in brgCLKEN ticks: half a bit to reach mid start bit,
  // then a full bit between successive samples.
  localparam logic [3:0] BRDIV_HALF   = 4'd7;
  localparam logic [3:0] BRDIV_FULL   = 4'd15;

  typedef enum logic [3:0] {
    RX_IDLE   = 4'd0,
    RX_START  = 4'd1,
    RX_BIT0   = 4'd2,
    RX_BIT1   = 4'd3,
    RX_BIT2   = 4'd4,
    RX_BIT3   = 4'd5,
    RX_BIT4   = 4'd6,
    RX_BIT5   = 4'd7,
    RX_BIT6   = 4'd8,
    RX_BIT7   = 4'd9,
    RX_PARITY = 4'd10,
    RX_STOP1  = 4'd11,
    RX_STOP2  = 4'd12,
    RX_DONE   = 4'd13
  } rx_state_e;

  // Index of the last data bit for a given length code (5..8 bits -> 4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    return {1'b0, len} + 3'd4;
  endfunction

  // Code 3 is a second "none" encoding.
  function automatic logic parity_on(input logic [1:0] par);
    return (par == UARTPAR_EVEN) || (par == UARTPAR_ODD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
//------------------------------------------------------------------------------
// Module   : uart_sync
// Purpose  : SYNC_STAGES-deep flip-flop synchroniser for an asynchronous
//            serial input; presets to 1 (line idle) on reset.
// Ports    : clk, rst (sync, active-high), d (async in), q (synchronised out)
// Params   : SYNC_STAGES (>= 2)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Preset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module   : uart_rx
// Purpose  : Unbuffered UART receiver (DZ11 receive half). Deserialises one
//            5-8 bit character with optional even/odd parity and 1 or 2 stop
//            bits, sampling mid-bit on a 16x baud clock enable.
// Ports    : clk, rst, clr (sync clear), length[1:0], parity[1:0], stop,
//            brgCLKEN, rxd (async), read -> data[7:0], full, intr, pare,
//            frme, ovre [, brk]
// Params   : SYNC_STAGES - rxd synchroniser depth (>= 2)
// Macro    : UART_RX_BREAK_EN - adds the brk output and break lock-out
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] length,
  input  logic [1:0] parity,
  input  logic       stop,
  input  logic       brgCLKEN,
  input  logic       rxd,
  input  logic       read,
  output logic [7:0] data,
  output logic       full,
  output logic       intr,
  output logic       pare,
  output logic       frme,
  output logic       ovre
`ifdef UART_RX_BREAK_EN
  ,
  output logic       brk
`endif
);

  logic sync_rst;
  logic rxs;

  assign sync_rst = rst | clr;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (sync_rst),
    .d   (rxd),
    .q   (rxs)
  );

  rx_state_e  state_q,   state_d;
  logic [3:0] brdiv_q,   brdiv_d;
  logic [7:0] sr_q,      sr_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;
  logic [7:0] data_q,    data_d;
  logic       full_q,    full_d;
  logic       intr_q,    intr_d;
  logic       pare_q,    pare_d;
  logic       frme_q,    frme_d;
  logic       ovre_q,    ovre_d;
`ifdef UART_RX_BREAK_EN
  logic       par_bit_q, par_bit_d;
  logic       brk_q,     brk_d;
`endif
  logic [2:0] bit_n;

  always_comb begin
    state_d   = state_q;
    brdiv_d   = brdiv_q;
    sr_d      = sr_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    data_d    = data_q;
    full_d    = full_q & ~read;
    intr_d    = 1'b0;
    pare_d    = pare_q;
    frme_d    = frme_q;
    ovre_d    = ovre_q;
`ifdef UART_RX_BREAK_EN
    par_bit_d = par_bit_q;
    brk_d     = brk_q;
`endif
    bit_n     = 3'(state_q - RX_BIT0);

    if (state_q == RX_DONE) begin
      // Completion ignores brgCLKEN; a coincident read loses to the new char.
      data_d  = sr_q;
      pare_d  = par_err_q;
      frme_d  = frm_err_q;
      full_d  = 1'b1;
      intr_d  = 1'b1;
      ovre_d  = full_q & ~read;
      state_d = RX_IDLE;
`ifdef UART_RX_BREAK_EN
      if ((sr_q == 8'h00) && !(parity_on(parity) && par_bit_q) && frm_err_q) begin
        brk_d = 1'b1;
      end
`endif
    end else if (brgCLKEN) begin
      if ((state_q != RX_IDLE) && (brdiv_q != 4'd0)) begin
        brdiv_d = brdiv_q - 4'd1;
      end

      case (state_q)
        RX_IDLE: begin
`ifdef UART_RX_BREAK_EN
          // A held break must return high before the receiver re-arms.
          if (rxs) begin
            brk_d = 1'b0;
          end
          if (!rxs && !brk_q) begin
            brdiv_d = BRDIV_HALF;
            state_d = RX_START;
          end
`else
          if (!rxs) begin
            brdiv_d = BRDIV_HALF;
            state_d = RX_START;
          end
`endif
        end

        RX_START: begin
          if (brdiv_q == 4'd0) begin
            if (rxs) begin
              state_d = RX_IDLE;
            end else begin
              brdiv_d   = BRDIV_FULL;
              sr_d      = 8'h00;
              par_err_d = 1'b0;
              state_d   = RX_BIT0;
`ifdef UART_RX_BREAK_EN
              par_bit_d = 1'b0;
`endif
            end
          end
        end

        RX_BIT0, RX_BIT1, RX_BIT2, RX_BIT3,
        RX_BIT4, RX_BIT5, RX_BIT6, RX_BIT7: begin
          if (brdiv_q == 4'd0) begin
            sr_d[bit_n] = rxs;
            brdiv_d     = BRDIV_FULL;
            if (bit_n == last_bit_idx(length)) begin
              state_d = parity_on(parity) ? RX_PARITY : RX_STOP1;
            end else begin
              state_d = rx_state_e'(state_q + 4'd1);
            end
          end
        end

        RX_PARITY: begin
          if (brdiv_q == 4'd0) begin
            // Unused upper bits of sr_q are zero, so the reduction covers
            // exactly the received data bits.
            par_err_d = ((^sr_q) ^ rxs) != (parity == UARTPAR_ODD);
            brdiv_d   = BRDIV_FULL;
            state_d   = RX_STOP1;
`ifdef UART_RX_BREAK_EN
            par_bit_d = rxs;
`endif
          end
        end

        RX_STOP1: begin
          if (brdiv_q == 4'd0) begin
            frm_err_d = ~rxs;
            brdiv_d   = BRDIV_FULL;
            state_d   = (stop == UARTSTOP_2) ? RX_STOP2 : RX_DONE;
          end
        end

        RX_STOP2: begin
          if (brdiv_q == 4'd0) begin
            state_d = RX_DONE;
          end
        end

        default: begin
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= RX_IDLE;
      brdiv_q   <= 4'd0;
      sr_q      <= 8'h00;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      data_q    <= 8'h00;
      full_q    <= 1'b0;
      intr_q    <= 1'b0;
      pare_q    <= 1'b0;
      frme_q    <= 1'b0;
      ovre_q    <= 1'b0;
`ifdef UART_RX_BREAK_EN
      par_bit_q <= 1'b0;
      brk_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      brdiv_q   <= brdiv_d;
      sr_q      <= sr_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      data_q    <= data_d;
      full_q    <= full_d;
      intr_q    <= intr_d;
      pare_q    <= pare_d;
      frme_q    <= frme_d;
      ovre_q    <= ovre_d;
`ifdef UART_RX_BREAK_EN
      par_bit_q <= par_bit_d;
      brk_q     <= brk_d;
`endif
    end
  end

  assign data = data_q;
  assign full = full_q;
  assign intr = intr_q;
  assign pare = pare_q;
  assign frme = frme_q;
  assign ovre = ovre_q;
`ifdef UART_RX_BREAK_EN
  assign brk  = brk_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Frames are built bit by bit from
//            the character format; a scoreboard of expected characters plus a
//            simple full/overrun model is checked against the DUT every cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int DIV     = 4;          // clk cycles per brgCLKEN pulse
  localparam int BIT_CYC = 16 * DIV;   // clk cycles per bit time

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [1:0] length = 2'd3;
  logic [1:0] parity = 2'd0;
  logic       stop = 1'b0;
  logic       brgCLKEN = 1'b0;
  logic       rxd = 1'b1;
  logic       read = 1'b0;
  logic [7:0] data;
  logic       full, intr, pare, frme, ovre;
`ifdef UART_RX_BREAK_EN
  logic       brk;
`endif

  uart_rx #(.SYNC_STAGES(2)) dut (
`ifdef UART_RX_BREAK_EN
    .brk      (brk),
`endif
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .length   (length),
    .parity   (parity),
    .stop     (stop),
    .brgCLKEN (brgCLKEN),
    .rxd      (rxd),
    .read     (read),
    .data     (data),
    .full     (full),
    .intr     (intr),
    .pare     (pare),
    .frme     (frme),
    .ovre     (ovre)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      brgCLKEN = (c == DIV - 1);
      c = (c + 1) % DIV;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  logic rst_e  = 1'b1;
  logic read_e = 1'b0;

  always @(posedge clk) begin
    rst_e  <= rst | clr;
    read_e <= read;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the scoreboard and the full/overrun model.
  initial begin
    exp_t       e;
    logic       mf;
    logic       prev_intr;
    logic [7:0] h_data;
    logic       h_pare, h_frme, h_ovre;
    mf = 1'b0; prev_intr = 1'b0;
    h_data = 8'h00; h_pare = 1'b0; h_frme = 1'b0; h_ovre = 1'b0;
    forever begin
      @(negedge clk);
      if (!chk_en) continue;
      if (rst_e) begin
        chk("rst_data", 32'(data), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_intr", 32'(intr), 0);
        chk("rst_flags", {29'd0, pare, frme, ovre}, 0);
        mf = 1'b0; prev_intr = 1'b0;
        h_data = 8'h00; h_pare = 1'b0; h_frme = 1'b0; h_ovre = 1'b0;
      end else begin
        if (intr) begin
          chk("intr_single", 32'(prev_intr), 0);
          chk("intr_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("char_data", 32'(data), 32'(e.d));
            chk("char_pare", 32'(pare), 32'(e.p));
            chk("char_frme", 32'(frme), 32'(e.f));
            chk("char_ovre", 32'(ovre), 32'(mf & ~read_e));
            h_data = e.d; h_pare = e.p; h_frme = e.f; h_ovre = mf & ~read_e;
          end
          mf = 1'b1;
        end else begin
          if (read_e) mf = 1'b0;
          chk("hold_data", 32'(data), 32'(h_data));
          chk("hold_flags", {29'd0, pare, frme, ovre}, {29'd0, h_pare, h_frme, h_ovre});
        end
        chk("full", 32'(full), 32'(mf));
        prev_intr = intr;
      end
    end
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * BIT_CYC) @(negedge clk);
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  // Sends one complete frame and queues the character it must produce.
  // rd_stop holds read during stop bit 1 until the character arrives.
  task automatic send_frame(input logic [7:0] ch, input logic [1:0] len,
                            input logic [1:0] par, input logic st,
                            input bit par_bad, input bit stop_low, input bit rd_stop);
    int         nb;
    logic [7:0] dm;
    bit         pon;
    logic       pb;
    int         ones;
    exp_t       e;
    nb  = 5 + int'(len);
    dm  = ch & (8'hFF >> (3 - int'(len)));
    pon = (par == 2'd1) || (par == 2'd2);
    // Even parity makes the total count of ones even; odd makes it odd.
    pb  = (($countones(dm) % 2) == 1) ^ (par == 2'd2) ^ par_bad;
    ones = $countones(dm) + int'(pb);
    e.d = dm;
    e.p = pon && (((ones % 2) == 1) != (par == 2'd2));
    e.f = stop_low;
    length = len; parity = par; stop = st;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(dm[i]);
    if (pon) drive_bit(pb);
    if (rd_stop) begin
      rxd  = ~stop_low;
      read = 1'b1;
      repeat (BIT_CYC) begin
        @(negedge clk);
        if (intr) read = 1'b0;
      end
      read = 1'b0;
    end else begin
      drive_bit(~stop_low);
    end
    if (st) drive_bit(1'b1);
    chk("frame_done", 32'(exp_q.size()), 0);
  endtask

  // Starts an 8N1 frame of ch and aborts it a quarter into data bit nbits.
  task automatic abort_frame(input logic [7:0] ch, input int nbits, input bit use_clr);
    length = 2'd3; parity = 2'd0; stop = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(ch[i]);
    rxd = ch[nbits];
    repeat (BIT_CYC / 4) @(negedge clk);
    if (use_clr) clr = 1'b1; else rst = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0; rst = 1'b0; rxd = 1'b1;
    chk("abort_data", 32'(data), 0);
    chk("abort_full", 32'(full), 0);
    chk("abort_flags", {29'd0, pare, frme, ovre}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ch;
    logic [1:0] len, par;
    logic       st;
    bit         pbad, slow;
    int         gap;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_data", 32'(data), 0);
    idle_bits(1);

    // 8N1 0xA5
    send_frame(8'hA5, 2'd3, 2'd0, 1'b0, 0, 0, 0);
    chk("a5_data", 32'(data), 32'h0A5);
    chk("a5_full", 32'(full), 1);
    chk("a5_flags", {29'd0, pare, frme, ovre}, 0);
    pulse_read();
    idle_bits(1);

    // 7E2 0x55 with bad parity, then a good one
    send_frame(8'h55, 2'd2, 2'd1, 1'b1, 1, 0, 0);
    chk("7e2_data", 32'(data), 32'h55);
    chk("7e2_pare_bad", 32'(pare), 1);
    pulse_read();
    send_frame(8'h55, 2'd2, 2'd1, 1'b1, 0, 0, 0);
    chk("7e2_pare_ok", 32'(pare), 0);
    pulse_read();
    idle_bits(1);

    // 5O1 0x1F with stop bit low; read clears full
    send_frame(8'h1F, 2'd0, 2'd2, 1'b0, 0, 1, 0);
    chk("5o1_data", 32'(data), 32'h1F);
    chk("5o1_frme", 32'(frme), 1);
    idle_bits(2);
    chk("5o1_full", 32'(full), 1);
    pulse_read();
    chk("5o1_read_clears", 32'(full), 0);
    idle_bits(1);

    // Overrun: back-to-back without read
    send_frame(8'h11, 2'd3, 2'd0, 1'b0, 0, 0, 0);
    send_frame(8'h22, 2'd3, 2'd0, 1'b0, 0, 0, 0);
    chk("ovr_data", 32'(data), 32'h22);
    chk("ovr_ovre", 32'(ovre), 1);
    pulse_read();
    idle_bits(1);

    // Read coincident with second completion
    send_frame(8'h11, 2'd3, 2'd0, 1'b0, 0, 0, 0);
    send_frame(8'h22, 2'd3, 2'd0, 1'b0, 0, 0, 1);
    chk("rdc_full", 32'(full), 1);
    chk("rdc_ovre", 32'(ovre), 0);
    pulse_read();
    idle_bits(1);

    // Short low glitch: false start, no character
    rxd = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    idle_bits(2);
    chk("glitch_full", 32'(full), 0);

    // Reset mid BIT3, clear mid BIT5, then good frames
    abort_frame(8'hF0, 3, 0);
    idle_bits(1);
    send_frame(8'h3C, 2'd3, 2'd0, 1'b0, 0, 0, 0);
    chk("after_rst_data", 32'(data), 32'h3C);
    abort_frame(8'hFF, 5, 1);
    idle_bits(1);
    send_frame(8'h96, 2'd3, 2'd1, 1'b0, 0, 0, 0);
    chk("after_clr_data", 32'(data), 32'h96);
    pulse_read();
    idle_bits(1);

`ifdef UART_RX_BREAK_EN
    begin
      exp_t eb;
      length = 2'd3; parity = 2'd0; stop = 1'b0;
      eb.d = 8'h00; eb.p = 1'b0; eb.f = 1'b1;
      exp_q.push_back(eb);
      rxd = 1'b0;
      repeat (30 * BIT_CYC) @(negedge clk);
      chk("brk_one_char", 32'(exp_q.size()), 0);
      chk("brk_set", 32'(brk), 1);
      chk("brk_data", 32'(data), 0);
      idle_bits(2);
      chk("brk_cleared", 32'(brk), 0);
      pulse_read();
    end
`endif

    // Randomised frames in random formats
    for (int i = 0; i < 30; i++) begin
      ch   = 8'($urandom);
      len  = 2'($urandom_range(0, 3));
      par  = 2'($urandom_range(0, 3));
      st   = 1'($urandom_range(0, 1));
      pbad = ($urandom_range(0, 3) == 0);
      slow = ($urandom_range(0, 7) == 0);
      send_frame(ch, len, par, st, pbad, slow, 0);
      gap = $urandom_range(0, 2);
      if (slow && gap == 0) gap = 1;
      if (gap > 0 && $urandom_range(0, 1) == 1) pulse_read();
      idle_bits(gap);
    end

    idle_bits(1);
    chk("end_no_pending", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
